// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the core pipeline and the stall/flush controller.
// Pure wiring: no state, no added latency.
// The controller applies backpressure upstream through pc_write and if_id_stall.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_mdu_start;
  logic             imem_ready;
  logic             pc_write;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_stall;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side: reports hazards, consumes the control decisions.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mdu_start, imem_ready,
    input  pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_stall,
           ctrl_state, stall_count
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mdu_start, imem_ready,
    output pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_stall,
           ctrl_state, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: boot bubble, load-use, branch redirect, fetch wait, MUL/DIV occupancy.
// Control outputs are combinational in the same cycle; state and counters update on the clock edge.
// Stalls the front end via pc_write/if_id_stall; holds EX via ex_stall while the MDU is busy.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int MDU_W  = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [MDU_W-1:0]  MDU_INIT  = MDU_W'(MDU_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_MDU  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [MDU_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0]  stall_count_q;
  logic              load_use;
  logic              pc_write;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // State and occupancy counters; reset abandons any boot or MDU sequence in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
      mdu_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      mdu_cnt_q  <= mdu_cnt_d;
    end
  end

  // Next state: BOOT and MDU leave on the edge where their counter is already zero.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    mdu_cnt_d  = mdu_cnt_q;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == '0) state_d = ST_RUN;
        else                  boot_cnt_d = boot_cnt_q - BOOT_W'(1);
      end
      ST_RUN: begin
        if (hz.ex_mdu_start) begin
          state_d   = ST_MDU;
          mdu_cnt_d = MDU_INIT;
        end
      end
      ST_MDU: begin
        if (mdu_cnt_q == '0) state_d = ST_RUN;
        else                 mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Control outputs; in RUN the hazards are resolved in priority order, MDU start first.
  always_comb begin
    pc_write       = 1'b0;
    hz.if_id_stall = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.ex_stall    = 1'b0;
    if (reset || state_q == ST_BOOT) begin
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (state_q == ST_MDU) begin
      hz.if_id_stall = 1'b1;
      hz.ex_stall    = 1'b1;
    end else if (hz.ex_mdu_start) begin
      hz.if_id_stall = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // The ID instruction is wrong-path, so its hazards and fetch wait do not matter.
      pc_write       = 1'b1;
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (load_use) begin
      hz.if_id_stall = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (!hz.imem_ready) begin
      hz.if_id_flush = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Lost-fetch counter: counts PC-hold cycles outside BOOT and saturates at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (state_q != ST_BOOT && !pc_write && stall_count_q != '1) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ctrl_state  = state_q;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for the hazard controller with a small expectation queue.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected stall_count is tracked by the bench from the expected pc_write/state.
module tb_pipeline_hazard_ctrl;

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_MDU  = 2'b10;

  // {pc_write, if_id_stall, if_id_flush, id_ex_flush, ex_stall}
  localparam logic [4:0] O_BOOT = 5'b00110;
  localparam logic [4:0] O_RUN  = 5'b10000;
  localparam logic [4:0] O_LU   = 5'b01010;
  localparam logic [4:0] O_BR   = 5'b10110;
  localparam logic [4:0] O_IM   = 5'b00100;
  localparam logic [4:0] O_MST  = 5'b01000;
  localparam logic [4:0] O_MDU  = 5'b01001;

  typedef struct {
    logic [1:0] st;
    logic [4:0] outs;
    logic [3:0] cnt;
    bit         chk_outs;
  } exp_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [3:0] exp_cnt;
  exp_t       q[$];
  string      tq[$];

  pipeline_hazard_ctrl_if #(.CNT_W(4)) hz();

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES(2),
    .MDU_LATENCY(4),
    .CNT_W      (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hz   (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input string tag, input string what,
                         input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s %s got %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    hz.id_rs1          = 5'd0;
    hz.id_rs2          = 5'd0;
    hz.id_uses_rs1     = 1'b0;
    hz.id_uses_rs2     = 1'b0;
    hz.ex_rd           = 5'd0;
    hz.ex_mem_read     = 1'b0;
    hz.ex_branch_taken = 1'b0;
    hz.ex_mdu_start    = 1'b0;
    hz.imem_ready      = 1'b1;
  endtask

  // One clock cycle: inputs already driven; push the expectation, check it mid-cycle, advance.
  task automatic cyc(input string tag, input logic [1:0] st,
                     input logic [4:0] outs, input bit chk_outs);
    exp_t e;
    e.st = st; e.outs = outs; e.cnt = exp_cnt; e.chk_outs = chk_outs;
    q.push_back(e);
    tq.push_back(tag);
    @(negedge clock);
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty got 0 expected 1", tag);
    end else begin
      exp_t  x;
      string t;
      x = q.pop_front();
      t = tq.pop_front();
      compare(t, "ctrl_state", {6'd0, hz.ctrl_state}, {6'd0, x.st});
      compare(t, "stall_count", {4'd0, hz.stall_count}, {4'd0, x.cnt});
      if (x.chk_outs) begin
        compare(t, "pc_write",    {7'd0, hz.pc_write},    {7'd0, x.outs[4]});
        compare(t, "if_id_stall", {7'd0, hz.if_id_stall}, {7'd0, x.outs[3]});
        compare(t, "if_id_flush", {7'd0, hz.if_id_flush}, {7'd0, x.outs[2]});
        compare(t, "id_ex_flush", {7'd0, hz.id_ex_flush}, {7'd0, x.outs[1]});
        compare(t, "ex_stall",    {7'd0, hz.ex_stall},    {7'd0, x.outs[0]});
      end
      // Expected counter after the coming edge.
      if (reset)                                  exp_cnt = 4'd0;
      else if (x.st != S_BOOT && !x.outs[4] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 4'd0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset held: BOOT outputs, counter clear.
    cyc("rst_hold", S_BOOT, O_BOOT, 1'b1);
    reset = 1'b0;

    // Boot bubble lasts exactly two cycles, then RUN with fetch enabled.
    cyc("boot0", S_BOOT, O_BOOT, 1'b1);
    cyc("boot1", S_BOOT, O_BOOT, 1'b1);
    cyc("run0",  S_RUN,  O_RUN,  1'b1);

    // Load-use on rs1.
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1;
    cyc("lu_rs1", S_RUN, O_LU, 1'b1);
    idle_inputs();
    cyc("lu_after", S_RUN, O_RUN, 1'b1);

    // x0 destination never stalls.
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_uses_rs1 = 1'b1;
    cyc("lu_rd0", S_RUN, O_RUN, 1'b1);

    // Matching register that is not actually read.
    hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b0;
    cyc("lu_unused", S_RUN, O_RUN, 1'b1);

    // Load-use on rs2.
    hz.ex_rd = 5'd7; hz.id_rs2 = 5'd7; hz.id_uses_rs2 = 1'b1;
    cyc("lu_rs2", S_RUN, O_LU, 1'b1);
    idle_inputs();

    // Branch beats load-use and fetch wait; no lost cycle.
    hz.ex_branch_taken = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5;
    hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1; hz.imem_ready = 1'b0;
    cyc("br_prio", S_RUN, O_BR, 1'b1);
    idle_inputs();
    cyc("br_after", S_RUN, O_RUN, 1'b1);

    // Single fetch wait.
    hz.imem_ready = 1'b0;
    cyc("imem_wait", S_RUN, O_IM, 1'b1);
    idle_inputs();

    // MDU: start cycle plus four busy cycles; branch and a second start are ignored.
    hz.ex_mdu_start = 1'b1;
    cyc("mdu_start", S_RUN, O_MST, 1'b1);
    idle_inputs();
    cyc("mdu_b0", S_MDU, O_MDU, 1'b1);
    hz.ex_branch_taken = 1'b1;
    cyc("mdu_b1_br", S_MDU, O_MDU, 1'b1);
    idle_inputs();
    hz.ex_mdu_start = 1'b1;
    cyc("mdu_b2_start", S_MDU, O_MDU, 1'b1);
    idle_inputs();
    cyc("mdu_b3", S_MDU, O_MDU, 1'b1);
    cyc("mdu_done", S_RUN, O_RUN, 1'b1);

    // Reset on the second MDU cycle abandons the op and restarts BOOT.
    hz.ex_mdu_start = 1'b1;
    cyc("mdu2_start", S_RUN, O_MST, 1'b1);
    idle_inputs();
    cyc("mdu2_b0", S_MDU, O_MDU, 1'b1);
    reset = 1'b1;
    cyc("mdu2_rst", S_MDU, O_MDU, 1'b0);
    reset = 1'b0;
    cyc("reboot0", S_BOOT, O_BOOT, 1'b1);
    cyc("reboot1", S_BOOT, O_BOOT, 1'b1);
    cyc("rerun",   S_RUN,  O_RUN,  1'b1);

    // Twenty fetch-wait cycles: counter saturates at 15 and holds.
    hz.imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("sat_%0d", i), S_RUN, O_IM, 1'b1);
    end
    idle_inputs();
    cyc("sat_hold", S_RUN, O_RUN, 1'b1);
    cyc("sat_hold2", S_RUN, O_RUN, 1'b1);

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain leftover got %0d expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
